bpred_ctrl: RTL

BPRED_CTRL -- requirements
Module: bpred_ctrl

---
 rtl/bpred_ctrl_if.sv | 46 ++++
 rtl/bpred_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bpred_ctrl_if.sv
// Bundle of lookup, retire-update and predictor-table signals for bpred_ctrl.
// slave is the controller side; master is the fetch/retire/table side.
interface bpred_ctrl_if #(
    parameter int LOGINDEX = 8,
    parameter int CTRWIDTH = 2,
    parameter int LOGFIFO  = 2
);
    logic                fetch_valid_in;
    logic [LOGINDEX-1:0] fetch_index_in;
    logic                pred_valid_out;
    logic                pred_taken_out;

    logic                upd_valid_in;
    logic [LOGINDEX-1:0] upd_index_in;
    logic                upd_taken_in;
    logic                upd_ready_out;
    logic [LOGFIFO:0]    upd_count_out;

    logic [LOGINDEX-1:0] ram_index1_out;
    logic [CTRWIDTH-1:0] ram_data1_in;
    logic                ram_we1_out;
    logic [LOGINDEX-1:0] ram_index2_out;
    logic [CTRWIDTH-1:0] ram_data2_in;
    logic [CTRWIDTH-1:0] ram_data2_out;
    logic                ram_we2_out;

    modport master (
        output fetch_valid_in, fetch_index_in,
        output upd_valid_in, upd_index_in, upd_taken_in,
        output ram_data1_in, ram_data2_in,
        input  pred_valid_out, pred_taken_out,
        input  upd_ready_out, upd_count_out,
        input  ram_index1_out, ram_we1_out,
        input  ram_index2_out, ram_data2_out, ram_we2_out
    );

    modport slave (
        input  fetch_valid_in, fetch_index_in,
        input  upd_valid_in, upd_index_in, upd_taken_in,
        input  ram_data1_in, ram_data2_in,
        output pred_valid_out, pred_taken_out,
        output upd_ready_out, upd_count_out,
        output ram_index1_out, ram_we1_out,
        output ram_index2_out, ram_data2_out, ram_we2_out
    );
endinterface

// File: rtl/bpred_ctrl.sv
// Branch predictor table controller: one-cycle lookup on table port 1 with write
// bypass, and a retire-update queue drained one entry per cycle into port 2.
module bpred_ctrl #(
    parameter int LOGINDEX  = 8,
    parameter int CTRWIDTH  = 2,
    parameter int LOGFIFO   = 2,
    parameter int FIFODEPTH = 4
) (
    input logic         clock,
    input logic         reset,
    bpred_ctrl_if.slave bus
);
    localparam logic [LOGFIFO:0]    DEPTH_C = (LOGFIFO+1)'(FIFODEPTH);
    localparam logic [LOGFIFO-1:0]  LAST_C  = LOGFIFO'(FIFODEPTH - 1);
    localparam logic [CTRWIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTRWIDTH-1:0] CTR_MIN = '0;

    function automatic logic [CTRWIDTH-1:0] sat_inc(input logic [CTRWIDTH-1:0] c);
        return (c == CTR_MAX) ? c : c + CTRWIDTH'(1);
    endfunction

    function automatic logic [CTRWIDTH-1:0] sat_dec(input logic [CTRWIDTH-1:0] c);
        return (c == CTR_MIN) ? c : c - CTRWIDTH'(1);
    endfunction

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [LOGFIFO-1:0] next_ptr(input logic [LOGFIFO-1:0] p);
        return (p == LAST_C) ? '0 : p + LOGFIFO'(1);
    endfunction

    logic [LOGFIFO-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOGFIFO-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOGFIFO:0]    count_q, count_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [LOGINDEX-1:0] fifo_index_q [FIFODEPTH];
    logic [LOGINDEX-1:0] fifo_index_d [FIFODEPTH];
    logic                fifo_taken_q [FIFODEPTH];
    logic                fifo_taken_d [FIFODEPTH];

    logic                empty, full, push, pop;
    logic [LOGINDEX-1:0] head_index;
    logic                head_taken;
    logic [CTRWIDTH-1:0] ctr_new;
    logic                we2;
    logic [LOGINDEX-1:0] index2;
    logic [CTRWIDTH-1:0] data2;
    logic [CTRWIDTH-1:0] ctr_eff;

    // Ready comes from registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign push  = bus.upd_valid_in && !full;
    assign pop   = !empty;

    assign head_index = fifo_index_q[rd_ptr_q];
    assign head_taken = fifo_taken_q[rd_ptr_q];

    always_comb begin
        ctr_new = head_taken ? sat_inc(bus.ram_data2_in) : sat_dec(bus.ram_data2_in);
        we2     = pop && (ctr_new != bus.ram_data2_in);
        index2  = pop ? head_index : '0;
        data2   = pop ? ctr_new : '0;
    end

    // A lookup that hits the entry being written this cycle sees the new value.
    always_comb begin
        ctr_eff = bus.ram_data1_in;
        if (we2 && (index2 == bus.fetch_index_in)) begin
            ctr_eff = data2;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fifo_index_d = fifo_index_q;
        fifo_taken_d = fifo_taken_q;
        if (push) begin
            fifo_index_d[wr_ptr_q] = bus.upd_index_in;
            fifo_taken_d[wr_ptr_q] = bus.upd_taken_in;
            wr_ptr_d               = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (LOGFIFO+1)'(1);
            2'b01:   count_d = count_q - (LOGFIFO+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pred_valid_d = bus.fetch_valid_in;
        pred_taken_d = pred_taken_q;
        if (bus.fetch_valid_in) begin
            pred_taken_d = ctr_eff[CTRWIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    // Queue storage is only meaningful under count_q, so it needs no reset.
    always_ff @(posedge clock) begin
        fifo_index_q <= fifo_index_d;
        fifo_taken_q <= fifo_taken_d;
    end

    assign bus.ram_index1_out = bus.fetch_index_in;
    assign bus.ram_we1_out    = 1'b0;
    assign bus.ram_index2_out = index2;
    assign bus.ram_data2_out  = data2;
    assign bus.ram_we2_out    = we2;
    assign bus.upd_ready_out  = !full;
    assign bus.upd_count_out  = count_q;
    assign bus.pred_valid_out = pred_valid_q;
    assign bus.pred_taken_out = pred_taken_q;
endmodule
